jk_flip_flop: RTL and testbench



---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_flip_flop_cell.sv | 28 ++
 rtl/jk_flip_flop.sv | 28 ++
 tb/tb_jk_flip_flop.sv | 125 ++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: {j,k} operation encodings and the per-bit
// next-state rule, reusable by other flip-flop blocks.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic cur, input jk_op_e op);
    logic nxt;
    nxt = cur;
    case (op)
      JK_HOLD: nxt = cur;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_flip_flop_cell.sv
// Single-bit JK flop: synchronous reset over set over enable-gated J/K.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic pr,
  input  logic ps,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // Declaration initialiser gives a defined state before the first reset.
  logic state = 1'b0;

  always_ff @(posedge clk) begin
    if (pr)
      state <= 1'b0;
    else if (ps)
      state <= 1'b1;
    else if (en)
      state <= jk_next(state, jk_op_e'({j, k}));
  end

  assign q = state;

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK cells sharing one reset, set and clock enable.
module jk_flip_flop
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             pr,
  input  logic             ps,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .pr  (pr),
      .ps  (ps),
      .en  (en),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop (WIDTH=4): directed steps, then random
// stimulus against a characteristic-equation reference model.
module tb_jk_flip_flop;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         pr  = 1'b0;
  logic         ps  = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] j   = '0;
  logic [W-1:0] k   = '0;
  logic [W-1:0] q;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [W-1:0] mq = '0;

  always #5 clk = ~clk;

  jk_flip_flop #(.WIDTH(W)) dut (
    .clk (clk),
    .pr  (pr),
    .ps  (ps),
    .en  (en),
    .j   (j),
    .k   (k),
    .q   (q)
  );

  // Q+ = J & ~Q | ~K & Q, overridden by reset, then set, then enable.
  function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic p, s, e,
                                         input logic [W-1:0] jj, kk);
    if (p) return '0;
    if (s) return '1;
    if (!e) return cur;
    return (jj & ~cur) | (~kk & cur);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    compared++;
    assert (q === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, q, exp);
    end
  endtask

  task automatic step(input logic p, s, e, input logic [W-1:0] jj, kk);
    pr = p; ps = s; en = e; j = jj; k = kk;
    @(posedge clk);
    mq = model(mq, p, s, e, jj, kk);
    #1;
  endtask

  // Pulse pr (sel=0) or ps (sel=1) entirely between two rising edges, en=0.
  task automatic pulse(input bit sel);
    pr = 1'b0; ps = 1'b0; en = 1'b0;
    #2;
    if (sel) ps = 1'b1; else pr = 1'b1;
    #2;
    pr = 1'b0; ps = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] jk;
    logic p, s, e;
    logic [W-1:0] rj, rk;

    #1;
    check("powerup", 4'b0000);

    for (int i = 0; i < 8; i++) begin
      jk = 2'(i);
      step(0, 0, 0, {W{jk[1]}}, {W{jk[0]}});
      check("en0_hold", 4'b0000);
    end

    step(1, 0, 1, 4'b1111, 4'b0000); check("pr_over_j", 4'b0000);
    step(0, 0, 1, 4'b1111, 4'b0000); check("j_after_pr", 4'b1111);

    step(1, 0, 0, 4'b0000, 4'b0000); check("pr_en0", 4'b0000);
    step(0, 1, 0, 4'b0000, 4'b0000); check("ps_en0", 4'b1111);
    step(0, 0, 0, 4'b0000, 4'b1111); check("hold_after_ps", 4'b1111);
    step(0, 0, 1, 4'b0000, 4'b1111); check("k_reset", 4'b0000);

    step(0, 1, 0, 4'b0000, 4'b0000);
    step(1, 1, 1, 4'b1111, 4'b1111); check("pr_beats_ps", 4'b0000);
    step(0, 1, 1, 4'b0000, 4'b1111); check("ps_beats_k", 4'b1111);

    step(1, 0, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 4'b1111, 4'b1111);
      check("toggle", (i % 2 == 0) ? 4'b1111 : 4'b0000);
    end
    step(0, 0, 1, 4'b1111, 4'b1111); check("toggle_pre_pr", 4'b1111);
    step(1, 0, 1, 4'b1111, 4'b1111); check("pr_mid_toggle", 4'b0000);
    step(0, 0, 1, 4'b1111, 4'b1111); check("resume_1", 4'b1111);
    step(0, 0, 1, 4'b1111, 4'b1111); check("resume_0", 4'b0000);

    step(0, 1, 0, 4'b0000, 4'b0000);
    pulse(1'b0); check("pr_glitch", 4'b1111);
    step(1, 0, 0, 4'b0000, 4'b0000);
    pulse(1'b1); check("ps_glitch", 4'b0000);

    step(0, 0, 1, 4'b0011, 4'b0000); check("load_0011", 4'b0011);
    step(0, 0, 1, 4'b1010, 4'b0110); check("per_bit_ops", 4'b1001);

    for (int i = 0; i < 200; i++) begin
      p  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rj = W'($urandom);
      rk = W'($urandom);
      step(p, s, e, rj, rk);
      check("random", mq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
